// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT frame controller and its capture buffer.
package fft_pkg;

    // Controller phases: collect a frame, let the FFT settle, stream the bins out.
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        DRAIN  = 2'd2
    } fft_ctrl_state_t;

    // Bit offset of element k inside a flat frame bus of sample_size-wide elements.
    function automatic int slice_offset(input int k, input int sample_size);
        return k * sample_size;
    endfunction

endpackage

// File: rtl/fft_bin_capture_buffer.sv
// Holds one frame of FFT results (real and imaginary per bin), loaded all at
// once by a capture strobe and read back one bin at a time by index.
module fft_bin_capture_buffer
    import fft_pkg::*;
#(
    parameter int BUFFER_SIZE = 32,
    parameter int SAMPLE_SIZE = 32,
    localparam int IDX_W      = $clog2(BUFFER_SIZE)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                capture,
    input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]  bus_real,
    input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]  bus_imag,
    input  logic [IDX_W-1:0]                    rd_idx,
    output logic signed [SAMPLE_SIZE-1:0]       rd_real,
    output logic signed [SAMPLE_SIZE-1:0]       rd_imag
);

    logic [SAMPLE_SIZE-1:0] bin_real_in [BUFFER_SIZE];
    logic [SAMPLE_SIZE-1:0] bin_imag_in [BUFFER_SIZE];
    logic [SAMPLE_SIZE-1:0] bin_real_reg [BUFFER_SIZE];
    logic [SAMPLE_SIZE-1:0] bin_imag_reg [BUFFER_SIZE];

    // Unpack the flat FFT result buses into per-bin words.
    genvar gi;
    generate
        for (gi = 0; gi < BUFFER_SIZE; gi++) begin : g_unpack
            assign bin_real_in[gi] = bus_real[slice_offset(gi, SAMPLE_SIZE) +: SAMPLE_SIZE];
            assign bin_imag_in[gi] = bus_imag[slice_offset(gi, SAMPLE_SIZE) +: SAMPLE_SIZE];
        end
    endgenerate

    // Snapshot every bin on the capture strobe; contents hold until the next capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < BUFFER_SIZE; k++) begin
                bin_real_reg[k] <= '0;
                bin_imag_reg[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < BUFFER_SIZE; k++) begin
                bin_real_reg[k] <= bin_real_in[k];
                bin_imag_reg[k] <= bin_imag_in[k];
            end
        end
    end

    // Read port is combinational so the output follows the index in the same cycle.
    assign rd_real = bin_real_reg[rd_idx];
    assign rd_imag = bin_imag_reg[rd_idx];

endmodule

// File: rtl/fft_frame_controller.sv
// Sequences a combinational FFT datapath: fills a frame from a valid/ready
// sample stream, holds it for a settle window, captures the results, then
// streams the bins out one per handshake.
module fft_frame_controller
    import fft_pkg::*;
#(
    parameter int BUFFER_SIZE   = 32,
    parameter int SAMPLE_SIZE   = 32,
    parameter int SETTLE_CYCLES = 4,
    localparam int IDX_W        = $clog2(BUFFER_SIZE)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [SAMPLE_SIZE-1:0]       in_sample,
    output logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]  fft_input_real,
    input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]  fft_output_real,
    input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]  fft_output_imag,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [SAMPLE_SIZE-1:0]       out_real,
    output logic signed [SAMPLE_SIZE-1:0]       out_imag,
    output logic [IDX_W-1:0]                    out_index,
    output logic                                out_last,
    output logic                                frame_done
);

    // Counter only ever holds SETTLE_CYCLES-1 down to 0.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(BUFFER_SIZE - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    fft_ctrl_state_t state_reg, state_next;
    logic [IDX_W-1:0] wr_idx_reg, wr_idx_next;
    logic [IDX_W-1:0] rd_idx_reg, rd_idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             write_en;
    logic             capture;

    logic [SAMPLE_SIZE-1:0] sample_reg [BUFFER_SIZE];
    logic signed [SAMPLE_SIZE-1:0] rd_real;
    logic signed [SAMPLE_SIZE-1:0] rd_imag;

    // State, index and settle counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= FILL;
            wr_idx_reg <= '0;
            rd_idx_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            wr_idx_reg <= wr_idx_next;
            rd_idx_reg <= rd_idx_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Next-state and handshake decode; ready/valid depend only on state and reset.
    always_comb begin
        state_next  = state_reg;
        wr_idx_next = wr_idx_reg;
        rd_idx_next = rd_idx_reg;
        cnt_next    = cnt_reg;
        write_en    = 1'b0;
        capture     = 1'b0;
        frame_done  = 1'b0;
        in_ready    = (state_reg == FILL) && !reset;
        out_valid   = (state_reg == DRAIN);

        case (state_reg)
            FILL: begin
                if (in_valid && in_ready) begin
                    write_en    = 1'b1;
                    wr_idx_next = wr_idx_reg + 1'b1;
                    if (wr_idx_reg == LAST_IDX) begin
                        cnt_next   = SETTLE_LOAD;
                        state_next = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_reg == '0) begin
                    capture     = 1'b1;
                    rd_idx_next = '0;
                    state_next  = DRAIN;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    rd_idx_next = rd_idx_reg + 1'b1;
                    if (rd_idx_reg == LAST_IDX) begin
                        frame_done = 1'b1;
                        state_next = FILL;
                    end
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Frame store; slots not rewritten keep their previous contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < BUFFER_SIZE; k++) begin
                sample_reg[k] <= '0;
            end
        end else if (write_en) begin
            sample_reg[wr_idx_reg] <= in_sample;
        end
    end

    // Pack the frame store onto the FFT input bus.
    genvar gi;
    generate
        for (gi = 0; gi < BUFFER_SIZE; gi++) begin : g_pack
            assign fft_input_real[slice_offset(gi, SAMPLE_SIZE) +: SAMPLE_SIZE] = sample_reg[gi];
        end
    endgenerate

    fft_bin_capture_buffer #(
        .BUFFER_SIZE (BUFFER_SIZE),
        .SAMPLE_SIZE (SAMPLE_SIZE)
    ) u_capture (
        .clk      (clk),
        .reset    (reset),
        .capture  (capture),
        .bus_real (fft_output_real),
        .bus_imag (fft_output_imag),
        .rd_idx   (rd_idx_reg),
        .rd_real  (rd_real),
        .rd_imag  (rd_imag)
    );

    // Bin outputs are forced to zero outside DRAIN so nothing stale leaks out.
    assign out_real  = out_valid ? rd_real : '0;
    assign out_imag  = out_valid ? rd_imag : '0;
    assign out_index = out_valid ? rd_idx_reg : '0;
    assign out_last  = out_valid && (rd_idx_reg == LAST_IDX);

endmodule

// File: tb/tb_fft_frame_controller.sv
// Directed bench for fft_frame_controller with a 4-point behavioural DFT
// standing in for the combinational FFT datapath.
module tb_fft_frame_controller;

    localparam int N  = 4;
    localparam int SW = 16;
    localparam int SC = 2;

    typedef logic signed [SW-1:0] smp_t;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic signed [SW-1:0] in_sample;
    logic [N*SW-1:0]   fft_input_real;
    logic [N*SW-1:0]   fft_output_real;
    logic [N*SW-1:0]   fft_output_imag;
    logic              out_valid;
    logic              out_ready;
    logic signed [SW-1:0] out_real;
    logic signed [SW-1:0] out_imag;
    logic [1:0]        out_index;
    logic              out_last;
    logic              frame_done;

    int vectors    = 0;
    int miscompares = 0;

    smp_t frame_in [N];
    smp_t exp_re [N];
    smp_t exp_im [N];
    logic [N*SW-1:0] exp_bus;

    fft_frame_controller #(
        .BUFFER_SIZE   (N),
        .SAMPLE_SIZE   (SW),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_sample       (in_sample),
        .fft_input_real  (fft_input_real),
        .fft_output_real (fft_output_real),
        .fft_output_imag (fft_output_imag),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_real        (out_real),
        .out_imag        (out_imag),
        .out_index       (out_index),
        .out_last        (out_last),
        .frame_done      (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4-point DFT of the real input frame.
    smp_t xs [N];
    smp_t fre [N];
    smp_t fim [N];
    always_comb begin
        for (int k = 0; k < N; k++) xs[k] = fft_input_real[k*SW +: SW];
        fre[0] = xs[0] + xs[1] + xs[2] + xs[3];
        fim[0] = '0;
        fre[1] = xs[0] - xs[2];
        fim[1] = xs[3] - xs[1];
        fre[2] = xs[0] - xs[1] + xs[2] - xs[3];
        fim[2] = '0;
        fre[3] = xs[0] - xs[2];
        fim[3] = xs[1] - xs[3];
    end
    assign fft_output_real = {fre[3], fre[2], fre[1], fre[0]};
    assign fft_output_imag = {fim[3], fim[2], fim[1], fim[0]};

    // Push the first n samples of frame_in; toggle inserts an idle cycle before each sample.
    task automatic feed(input int n, input bit toggle, input string tag);
        int k = 0;
        int cyc = 0;
        bit accepted;
        while (k < n && cyc < 60) begin
            in_valid  = toggle ? (cyc % 2 == 1) : 1'b1;
            in_sample = in_valid ? frame_in[k] : smp_t'(16'sh7777);
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL %s fill_in_ready: got %b want 1", tag, in_ready);
            end
            accepted = in_valid && in_ready;
            @(posedge clk); #1;
            if (accepted) begin
                $display("in  %s sample[%0d] = %0d", tag, k, frame_in[k]);
                k++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (k != n) begin
            miscompares++;
            $display("FAIL %s feed_timeout: accepted %0d want %0d", tag, k, n);
        end
    endtask

    // SETTLE must last exactly SC cycles with input blocked and the bus frozen.
    task automatic settle_check(input string tag);
        for (int c = 0; c < SC; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s settle_handshake c%0d: out_valid=%b in_ready=%b want 0/0",
                         tag, c, out_valid, in_ready);
            end
            vectors++;
            if (fft_input_real !== exp_bus) begin
                miscompares++;
                $display("FAIL %s settle_bus c%0d: got %h want %h", tag, c, fft_input_real, exp_bus);
            end
            @(posedge clk); #1;
        end
    endtask

    // Drain all bins, optionally stalling stall_cycles before bin stall_bin.
    task automatic drain_frame(input int stall_bin, input int stall_cycles, input string tag);
        for (int i = 0; i < N; i++) begin
            if (i == stall_bin) begin
                out_ready = 1'b0;
                for (int c = 0; c < stall_cycles; c++) begin
                    @(negedge clk);
                    vectors++;
                    if (out_valid !== 1'b1 || out_index !== 2'(i) || out_real !== exp_re[i] ||
                        out_imag !== exp_im[i] || in_ready !== 1'b0 || frame_done !== 1'b0) begin
                        miscompares++;
                        $display("FAIL %s stall bin%0d c%0d: v=%b idx=%0d re=%0d im=%0d rdy=%b fd=%b want 1/%0d/%0d/%0d/0/0",
                                 tag, i, c, out_valid, out_index, out_real, out_imag, in_ready,
                                 frame_done, i, exp_re[i], exp_im[i]);
                    end
                    @(posedge clk); #1;
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            $display("out %s bin %0d re=%0d im=%0d last=%b done=%b",
                     tag, out_index, out_real, out_imag, out_last, frame_done);
            vectors++;
            if (out_valid !== 1'b1 || out_index !== 2'(i)) begin
                miscompares++;
                $display("FAIL %s bin%0d valid_index: v=%b idx=%0d want 1/%0d", tag, i, out_valid, out_index, i);
            end
            vectors++;
            if (out_real !== exp_re[i] || out_imag !== exp_im[i]) begin
                miscompares++;
                $display("FAIL %s bin%0d value: re=%0d im=%0d want %0d/%0d",
                         tag, i, out_real, out_imag, exp_re[i], exp_im[i]);
            end
            vectors++;
            if (out_last !== (i == N-1) || frame_done !== (i == N-1) || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s bin%0d last_done: last=%b done=%b rdy=%b want %b/%b/0",
                         tag, i, out_last, frame_done, in_ready, i == N-1, i == N-1);
            end
            vectors++;
            if (fft_input_real !== exp_bus) begin
                miscompares++;
                $display("FAIL %s bin%0d drain_bus: got %h want %h", tag, i, fft_input_real, exp_bus);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_drain: v=%b rdy=%b fd=%b want 0/1/0", tag, out_valid, in_ready, frame_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic set_frame(input smp_t a, input smp_t b, input smp_t c, input smp_t d);
        frame_in[0] = a; frame_in[1] = b; frame_in[2] = c; frame_in[3] = d;
        exp_bus = {d, c, b, a};
    endtask

    task automatic set_bins(input smp_t r0, input smp_t r1, input smp_t r2, input smp_t r3,
                            input smp_t i0, input smp_t i1, input smp_t i2, input smp_t i3);
        exp_re[0] = r0; exp_re[1] = r1; exp_re[2] = r2; exp_re[3] = r3;
        exp_im[0] = i0; exp_im[1] = i1; exp_im[2] = i2; exp_im[3] = i3;
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s reset_flags: rdy=%b v=%b last=%b fd=%b want 0/0/0/0",
                     tag, in_ready, out_valid, out_last, frame_done);
        end
        vectors++;
        if (out_index !== 2'd0 || out_real !== 16'sd0 || out_imag !== 16'sd0 || fft_input_real !== '0) begin
            miscompares++;
            $display("FAIL %s reset_data: idx=%0d re=%0d im=%0d bus=%h want all 0",
                     tag, out_index, out_real, out_imag, fft_input_real);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset release: rdy=%b v=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_impulse();
        set_frame(1, 0, 0, 0);
        set_bins(1, 1, 1, 1, 0, 0, 0, 0);
        feed(4, 1'b0, "impulse");
        settle_check("impulse");
        drain_frame(-1, 0, "impulse");
    endtask

    task automatic test_constant();
        set_frame(5, 5, 5, 5);
        set_bins(20, 0, 0, 0, 0, 0, 0, 0);
        feed(4, 1'b0, "constant");
        settle_check("constant");
        drain_frame(-1, 0, "constant");
    endtask

    task automatic test_alternating();
        set_frame(1, 0, -1, 0);
        set_bins(0, 2, 0, 2, 0, 0, 0, 0);
        feed(4, 1'b1, "alternating");
        settle_check("alternating");
        drain_frame(-1, 0, "alternating");
    endtask

    task automatic test_backpressure();
        set_frame(2, 1, 0, -1);
        set_bins(2, 2, 2, 2, 0, -2, 0, 2);
        feed(4, 1'b0, "backpressure");
        settle_check("backpressure");
        drain_frame(2, 3, "backpressure");
    endtask

    task automatic test_reset_mid_fill();
        set_frame(7, 9, 0, 0);
        feed(2, 1'b0, "abort_fill");
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort_fill");
        @(posedge clk); #1;
        reset = 1'b0;
        set_frame(3, 3, 3, 3);
        set_bins(12, 0, 0, 0, 0, 0, 0, 0);
        feed(4, 1'b0, "after_abort");
        settle_check("after_abort");
        drain_frame(-1, 0, "after_abort");
    endtask

    task automatic test_reset_mid_drain();
        set_frame(1, 2, 3, 4);
        set_bins(10, -2, -2, -2, 0, 2, 0, -2);
        feed(4, 1'b0, "abort_drain");
        settle_check("abort_drain");
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_index !== 2'd0 || out_real !== 16'sd10) begin
            miscompares++;
            $display("FAIL abort_drain bin0: v=%b idx=%0d re=%0d want 1/0/10", out_valid, out_index, out_real);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        #2;
        vectors++;
        if (out_valid !== 1'b1 || out_index !== 2'd1 || out_real !== -16'sd2 || out_imag !== 16'sd2) begin
            miscompares++;
            $display("FAIL abort_drain bin1: v=%b idx=%0d re=%0d im=%0d want 1/1/-2/2",
                     out_valid, out_index, out_real, out_imag);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_index !== 2'd0 || out_real !== 16'sd0) begin
            miscompares++;
            $display("FAIL abort_drain async: v=%b idx=%0d re=%0d want 0/0/0", out_valid, out_index, out_real);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || fft_input_real !== '0) begin
            miscompares++;
            $display("FAIL abort_drain release: rdy=%b bus=%h want 1/0", in_ready, fft_input_real);
        end
        @(posedge clk); #1;
        set_frame(2, 0, 0, 0);
        set_bins(2, 2, 2, 2, 0, 0, 0, 0);
        feed(4, 1'b0, "after_drain_abort");
        settle_check("after_drain_abort");
        drain_frame(-1, 0, "after_drain_abort");
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_constant();
        test_alternating();
        test_backpressure();
        test_reset_mid_fill();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
